fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_wr_fifo.sv | 58 +++++
 rtl/fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry and arbiter state encoding shared by fb_arbiter and its FIFO.
package fb_pkg;
   localparam int unsigned HTILES  = 80;
   localparam int unsigned VTILES  = 60;
   localparam int unsigned FB_SIZE = HTILES * VTILES;
   localparam int unsigned ADDR_W  = $clog2(FB_SIZE);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_CLEAR = 2'd2
   } fb_state_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Host write FIFO: valid/ready push, pop of the head, full/empty flags.
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = ADDR_W + 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [PW:0]  wptr_q, wptr_d;
   logic [PW:0]  rptr_q, rptr_d;
   logic         do_push;
   logic         do_pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   always_comb begin
      empty      = (wptr_q == rptr_q);
      full       = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
      do_pop     = pop && !empty;
      push_ready = !full || do_pop;
      do_push    = push_valid && push_ready;
      head       = mem_q[rptr_q[PW-1:0]];
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      if (do_push) begin
         mem_d[wptr_q[PW-1:0]] = push_data;
         wptr_d                = wptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
      mem_q <= mem_d;
   end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer RAM arbiter: scan read > clear write > queued host write.
// Define FB_CLEAR_EN to build the clear engine (DRAIN/CLEAR states and fill latch).
module fb_arbiter
   import fb_pkg::*;
#(
   parameter  int unsigned HTILES     = fb_pkg::HTILES,
   parameter  int unsigned VTILES     = fb_pkg::VTILES,
   parameter  int unsigned FIFO_DEPTH = 4,
   localparam int unsigned FB_N       = HTILES * VTILES,
   localparam int unsigned AW         = $clog2(FB_N)
) (
   input  logic          px_clk,
   input  logic          rst,
   input  logic          i_scan_req,
   input  logic [AW-1:0] i_scan_addr,
   output logic [7:0]    o_scan_data,
   output logic          o_scan_valid,
   input  logic          i_wr_valid,
   input  logic [AW-1:0] i_wr_addr,
   input  logic [7:0]    i_wr_data,
   output logic          o_wr_ready,
   input  logic          i_clear,
   input  logic [7:0]    i_fill,
   output logic          o_busy,
   output logic          o_err_oob,
   output logic [AW-1:0] o_ram_addr,
   output logic          o_ram_we,
   output logic [7:0]    o_ram_wdata,
   input  logic [7:0]    i_ram_rdata
);
   localparam logic [AW-1:0] LAST_ADDR = AW'(FB_N - 1);

   fb_state_e     state_q, state_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic          scan_valid_q, scan_valid_d;
   logic          err_q, err_d;
   logic          wr_in_range, push_valid, fifo_push_ready, fifo_pop;
   logic          fifo_full, fifo_empty, clear_we, unused_ok;
   logic [AW+7:0] fifo_head;
`ifdef FB_CLEAR_EN
   logic [AW-1:0] cnt_q, cnt_d;
   logic [7:0]    fill_q, fill_d;
`endif

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (AW + 8)
   ) u_fifo (
      .clk        (px_clk),
      .rst        (rst),
      .push_valid (push_valid),
      .push_ready (fifo_push_ready),
      .push_data  ({i_wr_addr, i_wr_data}),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   always_comb begin
      o_wr_ready   = !fifo_full && (state_q == ST_IDLE);
      wr_in_range  = (i_wr_addr <= LAST_ADDR);
      push_valid   = i_wr_valid && o_wr_ready && wr_in_range;
      err_d        = err_q || (i_wr_valid && o_wr_ready && !wr_in_range);
      scan_valid_d = i_scan_req;
      state_d      = state_q;
`ifdef FB_CLEAR_EN
      cnt_d    = cnt_q;
      fill_d   = fill_q;
      clear_we = (state_q == ST_CLEAR) && !i_scan_req && !rst;
      o_busy   = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (i_clear) begin
               fill_d  = i_fill;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty) begin
               cnt_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (clear_we) begin
               if (cnt_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      unused_ok = fifo_push_ready;
`else
      clear_we  = 1'b0;
      o_busy    = 1'b0;
      state_d   = ST_IDLE;
      unused_ok = ^{fifo_push_ready, i_clear, i_fill};
`endif
      // The address register only moves on granted cycles, so idle cycles hold it.
      fifo_pop    = !i_scan_req && !clear_we && !rst;
      o_ram_we    = 1'b0;
      o_ram_wdata = fifo_head[7:0];
      ram_addr_d  = ram_addr_q;
      if (i_scan_req) begin
         ram_addr_d = i_scan_addr;
      end else if (clear_we) begin
         o_ram_we   = 1'b1;
`ifdef FB_CLEAR_EN
         ram_addr_d  = cnt_q;
         o_ram_wdata = fill_q;
`endif
      end else if (fifo_pop && !fifo_empty) begin
         o_ram_we   = 1'b1;
         ram_addr_d = fifo_head[AW+7:8];
      end
      o_ram_addr   = ram_addr_d;
      o_scan_valid = scan_valid_q;
      o_scan_data  = scan_valid_q ? i_ram_rdata : '0;
      o_err_oob    = err_q;
   end

   always_ff @(posedge px_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ram_addr_q   <= '0;
         scan_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ram_addr_q   <= ram_addr_d;
         scan_valid_q <= scan_valid_d;
         err_q        <= err_d;
      end
   end

`ifdef FB_CLEAR_EN
   always_ff @(posedge px_clk) begin
      if (rst) begin
         cnt_q  <= '0;
         fill_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         fill_q <= fill_d;
      end
   end
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: cycle vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_fb_arbiter;
   logic        px_clk = 1'b0;
   logic        rst;
   logic        i_scan_req;
   logic [12:0] i_scan_addr;
   logic [7:0]  o_scan_data;
   logic        o_scan_valid;
   logic        i_wr_valid;
   logic [12:0] i_wr_addr;
   logic [7:0]  i_wr_data;
   logic        o_wr_ready;
   logic        i_clear;
   logic [7:0]  i_fill;
   logic        o_busy;
   logic        o_err_oob;
   logic [12:0] o_ram_addr;
   logic        o_ram_we;
   logic [7:0]  o_ram_wdata;
   logic [7:0]  ram_rdata;
   logic [7:0]  ram [0:8191];

   int checks = 0;
   int passes = 0;

   always #5 px_clk = ~px_clk;

   fb_arbiter #(
      .HTILES     (80),
      .VTILES     (60),
      .FIFO_DEPTH (4)
   ) dut (
      .px_clk       (px_clk),
      .rst          (rst),
      .i_scan_req   (i_scan_req),
      .i_scan_addr  (i_scan_addr),
      .o_scan_data  (o_scan_data),
      .o_scan_valid (o_scan_valid),
      .i_wr_valid   (i_wr_valid),
      .i_wr_addr    (i_wr_addr),
      .i_wr_data    (i_wr_data),
      .o_wr_ready   (o_wr_ready),
      .i_clear      (i_clear),
      .i_fill       (i_fill),
      .o_busy       (o_busy),
      .o_err_oob    (o_err_oob),
      .o_ram_addr   (o_ram_addr),
      .o_ram_we     (o_ram_we),
      .o_ram_wdata  (o_ram_wdata),
      .i_ram_rdata  (ram_rdata)
   );

   // Synchronous single-port RAM with one cycle of read latency.
   always @(posedge px_clk) begin
      if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
      ram_rdata <= ram[o_ram_addr];
   end

   typedef struct {
      logic        sreq;
      logic [12:0] saddr;
      logic        wv;
      logic [12:0] waddr;
      logic [7:0]  wdata;
      logic        e_we;
      logic [12:0] e_addr;
      logic [7:0]  e_wdata;
      logic        e_ready;
      logic        e_sv;
      logic [7:0]  e_sd;
      logic        e_oob;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic next_cycle();
      @(negedge px_clk);
   endtask

   task automatic set_in(input logic sreq, input logic [12:0] saddr, input logic wv,
                         input logic [12:0] waddr, input logic [7:0] wdata);
      i_scan_req  = sreq;
      i_scan_addr = saddr;
      i_wr_valid  = wv;
      i_wr_addr   = waddr;
      i_wr_data   = wdata;
   endtask

   initial begin
      int k;
      int nwe;
      logic found;
      for (int i = 0; i < 8192; i++) ram[i] = 8'(i);

      vecs[0]  = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b0, 13'd79,   8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[1]  = '{1'b1, 13'd5,    1'b0, 13'd0,    8'h00, 1'b0, 13'd5,    8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[2]  = '{1'b1, 13'd6,    1'b1, 13'd4799, 8'h41, 1'b0, 13'd6,    8'h00, 1'b1, 1'b1, 8'h05, 1'b0};
      vecs[3]  = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b1, 13'd4799, 8'h41, 1'b1, 1'b1, 8'h06, 1'b0};
      vecs[4]  = '{1'b1, 13'd4799, 1'b0, 13'd0,    8'h00, 1'b0, 13'd4799, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[5]  = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b0, 13'd4799, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0};
      vecs[6]  = '{1'b0, 13'd0,    1'b1, 13'd4800, 8'h99, 1'b0, 13'd4799, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[7]  = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b0, 13'd4799, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[8]  = '{1'b1, 13'd20,   1'b1, 13'd10,   8'h07, 1'b0, 13'd20,   8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[9]  = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b1, 13'd10,   8'h07, 1'b1, 1'b1, 8'h14, 1'b1};
      vecs[10] = '{1'b0, 13'd0,    1'b1, 13'd8191, 8'hEE, 1'b0, 13'd10,   8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[11] = '{1'b1, 13'd10,   1'b0, 13'd0,    8'h00, 1'b0, 13'd10,   8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vecs[12] = '{1'b0, 13'd0,    1'b0, 13'd0,    8'h00, 1'b0, 13'd10,   8'h00, 1'b1, 1'b1, 8'h07, 1'b1};

      rst = 1'b1;
      i_clear = 1'b0;
      i_fill = 8'h00;
      set_in(1'b0, 13'd0, 1'b0, 13'd0, 8'h00);
      repeat (3) next_cycle();
      rst = 1'b0;
      #1;
      check("reset_outputs", {o_scan_valid, o_ram_we, o_busy, o_err_oob, o_ram_addr, o_scan_data, o_wr_ready},
            {1'b0, 1'b0, 1'b0, 1'b0, 13'd0, 8'h00, 1'b1});

      // Back-to-back scan reads of the preloaded pattern.
      for (int i = 0; i <= 80; i++) begin
         next_cycle();
         if (i < 80) set_in(1'b1, 13'(i), 1'b0, 13'd0, 8'h00);
         else set_in(1'b0, 13'd0, 1'b0, 13'd0, 8'h00);
         #1;
         if (i < 80) check($sformatf("scan_grant%0d", i), {o_ram_we, o_ram_addr}, {1'b0, 13'(i)});
         if (i > 0) check($sformatf("scan_data%0d", i - 1), {o_scan_valid, o_scan_data}, {1'b1, 8'(i - 1)});
      end

      for (int v = 0; v < 13; v++) begin
         next_cycle();
         set_in(vecs[v].sreq, vecs[v].saddr, vecs[v].wv, vecs[v].waddr, vecs[v].wdata);
         #1;
         check($sformatf("vec%0d", v),
               {o_ram_we, o_ram_addr, (o_ram_we ? o_ram_wdata : 8'h00), o_wr_ready, o_scan_valid, o_scan_data, o_err_oob},
               {vecs[v].e_we, vecs[v].e_addr, (vecs[v].e_we ? vecs[v].e_wdata : 8'h00),
                vecs[v].e_ready, vecs[v].e_sv, vecs[v].e_sd, vecs[v].e_oob});
      end

      // Continuous scan starves the FIFO; five offered writes, four fit.
      k = 0;
      nwe = 0;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         set_in(1'b1, 13'd0, (k < 5), 13'(100 + k), 8'(8'hA0 + k));
         #1;
         if (o_ram_we) nwe++;
         if (i_wr_valid && o_wr_ready) k++;
      end
      check("starve_accepts", 64'(k), 64'd4);
      check("starve_ready_low", {63'd0, o_wr_ready}, 64'd0);
      check("starve_no_writes", 64'(nwe), 64'd0);
      for (int j = 0; j < 4; j++) begin
         next_cycle();
         set_in(1'b0, 13'd0, 1'b0, 13'd0, 8'h00);
         #1;
         check($sformatf("retire%0d", j), {o_ram_we, o_ram_addr, o_ram_wdata}, {1'b1, 13'(100 + j), 8'(8'hA0 + j)});
      end
      next_cycle();
      #1;
      check("retire_done", {o_ram_we, o_wr_ready}, {1'b0, 1'b1});

`ifdef FB_CLEAR_EN
      begin
         int pre;
         int fills;
         int seq_err;
         logic done;
         next_cycle();
         set_in(1'b1, 13'd0, 1'b1, 13'd300, 8'h11);
         next_cycle();
         set_in(1'b1, 13'd0, 1'b1, 13'd301, 8'h12);
         pre = 0;
         fills = 0;
         seq_err = 0;
         done = 1'b0;
         for (int c = 0; c < 6000 && !done; c++) begin
            next_cycle();
            set_in((c % 97) == 5, 13'd7, 1'b0, 13'd0, 8'h00);
            i_clear = (c == 0) || (c == 50);
            i_fill  = (c == 0) ? 8'h20 : ((c == 50) ? 8'h77 : 8'h00);
            #1;
            if (c == 1) check("clear_busy_high", {o_busy, o_wr_ready}, {1'b1, 1'b0});
            if (o_ram_we) begin
               if (pre < 2) begin
                  if (o_ram_addr != 13'(300 + pre) || o_ram_wdata != 8'(8'h11 + pre)) seq_err++;
                  pre++;
               end else begin
                  if (o_ram_addr != 13'(fills) || o_ram_wdata != 8'h20) seq_err++;
                  fills++;
               end
            end
            if (c > 2 && !o_busy) done = 1'b1;
         end
         i_clear = 1'b0;
         check("clear_finished", {63'd0, done}, 64'd1);
         check("clear_prewrites", 64'(pre), 64'd2);
         check("clear_fill_count", 64'(fills), 64'd4800);
         check("clear_sequence_errors", 64'(seq_err), 64'd0);

         next_cycle();
         set_in(1'b0, 13'd0, 1'b1, 13'd500, 8'h55);
         #1;
         check("post_clear_ready", {o_wr_ready, o_busy}, {1'b1, 1'b0});
         next_cycle();
         set_in(1'b0, 13'd0, 1'b0, 13'd0, 8'h00);
         #1;
         check("post_clear_write", {o_ram_we, o_ram_addr, o_ram_wdata}, {1'b1, 13'd500, 8'h55});
         next_cycle();
         set_in(1'b1, 13'd500, 1'b0, 13'd0, 8'h00);
         next_cycle();
         set_in(1'b1, 13'd300, 1'b0, 13'd0, 8'h00);
         #1;
         check("readback_500", {o_scan_valid, o_scan_data}, {1'b1, 8'h55});
         next_cycle();
         set_in(1'b0, 13'd0, 1'b0, 13'd0, 8'h00);
         #1;
         check("readback_300_filled", {o_scan_valid, o_scan_data}, {1'b1, 8'h20});

         // Reset lands while the fill counter is at 1000.
         next_cycle();
         i_clear = 1'b1;
         i_fill = 8'h33;
         found = 1'b0;
         for (int c = 0; c < 3000 && !found; c++) begin
            next_cycle();
            i_clear = 1'b0;
            #1;
            if (o_ram_we && o_ram_addr == 13'd1000) found = 1'b1;
         end
         check("reach_counter_1000", {63'd0, found}, 64'd1);
         rst = 1'b1;
         next_cycle();
         rst = 1'b0;
         #1;
         check("abort_state", {o_busy, o_ram_we, o_wr_ready, o_err_oob}, {1'b0, 1'b0, 1'b1, 1'b0});
         nwe = 0;
         for (int c = 0; c < 50; c++) begin
            next_cycle();
            #1;
            if (o_ram_we) nwe++;
         end
         check("abort_no_fill_writes", 64'(nwe), 64'd0);
      end
`else
      nwe = 0;
      k = 0;
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         i_clear = (c == 0);
         i_fill = 8'h20;
         #1;
         if (o_ram_we) nwe++;
         if (o_busy || !o_wr_ready) k++;
      end
      i_clear = 1'b0;
      check("clear_ignored_writes", 64'(nwe), 64'd0);
      check("clear_ignored_busy", 64'(k), 64'd0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      #1;
      check("oob_cleared_by_reset", {o_err_oob, o_busy, o_wr_ready}, {1'b0, 1'b0, 1'b1});
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
